wash_cycle_controller: RTL and testbench

Top-level sequencer for one wash programme: starts load sensing, then runs fill, wash, drain and spin phases with per-phase timers. Drives the start input of the load-sensing block and consumes its load_ready. Guards every phase with timeouts and a door interlock, and reports faults with a code.

---
 rtl/wash_pkg.sv | 33 +++
 rtl/phase_timer.sv | 26 ++
 rtl/wash_cycle_controller.sv | 154 +++++++++++++++
 tb/tb_wash_cycle_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared encodings and default phase durations for the wash programme sequencer.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SENSE = 3'd1,
        FILL  = 3'd2,
        WASH  = 3'd3,
        DRAIN = 3'd4,
        SPIN  = 3'd5,
        DONE  = 3'd6,
        FAULT = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_SENSE   = 2'd1,
        FC_TIMEOUT = 2'd2,
        FC_DOOR    = 2'd3
    } fault_code_t;

    localparam int DEF_SENSE_TIMEOUT = 32;
    localparam int DEF_MAX_RETRY     = 2;
    localparam int DEF_FILL_TIMEOUT  = 64;
    localparam int DEF_WASH_CYCLES   = 100;
    localparam int DEF_DRAIN_TIMEOUT = 64;
    localparam int DEF_SPIN_CYCLES   = 50;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer: counts cycles since the last clear, saturates, and flags the terminal count.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clear || !enable) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == limit);

endmodule

// File: rtl/wash_cycle_controller.sv
// Wash programme sequencer: SENSE -> FILL -> WASH -> DRAIN -> SPIN -> DONE with timeouts,
// sense retries and a door interlock; outputs are registered from the next state.
module wash_cycle_controller
    import wash_pkg::*;
#(
    parameter int SENSE_TIMEOUT = DEF_SENSE_TIMEOUT,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int FILL_TIMEOUT  = DEF_FILL_TIMEOUT,
    parameter int WASH_CYCLES   = DEF_WASH_CYCLES,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int SPIN_CYCLES   = DEF_SPIN_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       door_closed,
    input  logic       load_ready,
    input  logic       water_full,
    input  logic       water_empty,
    input  logic       clear_fault,
    output logic       sense_start,
    output logic       valve_open,
    output logic       drum_motor,
    output logic       drain_pump,
    output logic       spin_motor,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    localparam int MAX_DUR = max_of(max_of(max_of(SENSE_TIMEOUT, FILL_TIMEOUT), max_of(WASH_CYCLES, DRAIN_TIMEOUT)), SPIN_CYCLES);
    localparam int TW      = $clog2(MAX_DUR) + 1;
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t      st, nxt;
    fault_code_t fc_q, fc_nxt;
    logic [RW-1:0] retry;
    logic          retry_now;
    logic [TW-1:0] limit;
    logic          timer_en, expired;

    assign timer_en = st inside {SENSE, FILL, WASH, DRAIN, SPIN};

    always_comb begin
        limit = '0;
        case (st)
            SENSE:   limit = TW'(SENSE_TIMEOUT - 1);
            FILL:    limit = TW'(FILL_TIMEOUT - 1);
            WASH:    limit = TW'(WASH_CYCLES - 1);
            DRAIN:   limit = TW'(DRAIN_TIMEOUT - 1);
            SPIN:    limit = TW'(SPIN_CYCLES - 1);
            default: limit = '0;
        endcase
    end

    // A sense retry restarts the timer without leaving SENSE.
    phase_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((nxt != st) || retry_now),
        .enable  (timer_en),
        .limit   (limit),
        .expired (expired)
    );

    // Within a cycle the door interlock outranks a timeout, which outranks a completion event.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        nxt       = st;
        fc_nxt    = fc_q;
        retry_now = 1'b0;
        if (timer_en && !door_closed) begin
            nxt    = FAULT;
            fc_nxt = FC_DOOR;
        end else begin
            case (st)
                IDLE:  if (start_btn && door_closed) nxt = SENSE;
                SENSE: begin
                    if (expired) begin
                        if (retry == RW'(MAX_RETRY)) begin
                            nxt    = FAULT;
                            fc_nxt = FC_SENSE;
                        end else begin
                            retry_now = 1'b1;
                        end
                    end else if (load_ready) begin
                        nxt = FILL;
                    end
                end
                FILL: begin
                    if (expired) begin
                        nxt    = FAULT;
                        fc_nxt = FC_TIMEOUT;
                    end else if (water_full) begin
                        nxt = WASH;
                    end
                end
                WASH:  if (expired) nxt = DRAIN;
                DRAIN: begin
                    if (expired) begin
                        nxt    = FAULT;
                        fc_nxt = FC_TIMEOUT;
                    end else if (water_empty) begin
                        nxt = SPIN;
                    end
                end
                SPIN:  if (expired) nxt = DONE;
                DONE:  if (!door_closed) nxt = IDLE;
                FAULT: begin
                    if (clear_fault) begin
                        nxt    = IDLE;
                        fc_nxt = FC_NONE;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st          <= IDLE;
            fc_q        <= FC_NONE;
            retry       <= '0;
            sense_start <= 1'b0;
            valve_open  <= 1'b0;
            drum_motor  <= 1'b0;
            drain_pump  <= 1'b0;
            spin_motor  <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            st          <= nxt;
            fc_q        <= fc_nxt;
            if (retry_now) begin
                retry <= retry + RW'(1);
            end else if (nxt == IDLE) begin
                retry <= '0;
            end
            sense_start <= (nxt == SENSE) && !retry_now;
            valve_open  <= (nxt == FILL);
            drum_motor  <= (nxt == WASH);
            drain_pump  <= (nxt == DRAIN) || (nxt == SPIN);
            spin_motor  <= (nxt == SPIN);
            done        <= (nxt == DONE);
            fault       <= (nxt == FAULT);
        end
    end

    assign fault_code = fc_q;
    assign state      = st;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller with a phase/age reference model checked every cycle.
module tb_wash_cycle_controller;

    localparam int SENSE_T   = 16;
    localparam int MAX_RETRY = 2;
    localparam int FILL_T    = 16;
    localparam int WASH_N    = 20;
    localparam int DRAIN_T   = 16;
    localparam int SPIN_N    = 10;

    logic clk = 1'b0;
    logic reset = 1'b0, start_btn = 1'b0, door_closed = 1'b1, load_ready = 1'b0;
    logic water_full = 1'b0, water_empty = 1'b0, clear_fault = 1'b0;
    logic sense_start, valve_open, drum_motor, drain_pump, spin_motor, done, fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wash_cycle_controller #(
        .SENSE_TIMEOUT (SENSE_T),
        .MAX_RETRY     (MAX_RETRY),
        .FILL_TIMEOUT  (FILL_T),
        .WASH_CYCLES   (WASH_N),
        .DRAIN_TIMEOUT (DRAIN_T),
        .SPIN_CYCLES   (SPIN_N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .door_closed (door_closed),
        .load_ready  (load_ready),
        .water_full  (water_full),
        .water_empty (water_empty),
        .clear_fault (clear_fault),
        .sense_start (sense_start),
        .valve_open  (valve_open),
        .drum_motor  (drum_motor),
        .drain_pump  (drain_pump),
        .spin_motor  (spin_motor),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code),
        .state       (state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: phase number plus cycles spent in it. The SENSE age is never
    // restarted by a retry; attempt boundaries fall on multiples of SENSE_T instead.
    int m_phase = 0, m_age = 0, m_code = 0;
    bit m_live = 1'b0;

    function automatic int phase_len(input int ph);
        case (ph)
            1: return SENSE_T;
            2: return FILL_T;
            3: return WASH_N;
            4: return DRAIN_T;
            5: return SPIN_N;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit last;
        if (!reset) begin
            m_phase = 0; m_age = 0; m_code = 0; m_live = 1'b1;
        end else if (m_live) begin
            nxt  = m_phase;
            last = (m_phase >= 1 && m_phase <= 5) && ((m_age + 1) % phase_len(m_phase) == 0);
            if (m_phase >= 1 && m_phase <= 5 && !door_closed) begin
                nxt = 7; m_code = 3;
            end else if (m_phase == 0) begin
                if (start_btn && door_closed) nxt = 1;
            end else if (m_phase == 1) begin
                if (last) begin
                    if (m_age + 1 == SENSE_T * (MAX_RETRY + 1)) begin nxt = 7; m_code = 1; end
                end else if (load_ready) nxt = 2;
            end else if (m_phase == 2) begin
                if (last) begin nxt = 7; m_code = 2; end
                else if (water_full) nxt = 3;
            end else if (m_phase == 3) begin
                if (last) nxt = 4;
            end else if (m_phase == 4) begin
                if (last) begin nxt = 7; m_code = 2; end
                else if (water_empty) nxt = 5;
            end else if (m_phase == 5) begin
                if (last) nxt = 6;
            end else if (m_phase == 6) begin
                if (!door_closed) nxt = 0;
            end else begin
                if (clear_fault) begin nxt = 0; m_code = 0; end
            end
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
        end
    end

    function automatic logic [11:0] model_vec();
        logic ss;
        ss = (m_phase == 1) && !(m_age > 0 && m_age % SENSE_T == 0);
        return {3'(m_phase), 2'(m_code), ss, m_phase == 2, m_phase == 3,
                m_phase == 4 || m_phase == 5, m_phase == 5, m_phase == 6, m_phase == 7};
    endfunction

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            check("cycle outputs",
                  {20'd0, state, fault_code, sense_start, valve_open, drum_motor,
                   drain_pump, spin_motor, done, fault},
                  {20'd0, model_vec()});
            check("actuator exclusive", 32'((valve_open + drum_motor + spin_motor) <= 2'd1), 32'd1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog();
        start_btn = 1'b1; cyc(); start_btn = 1'b0;
    endtask

    task automatic sense_ok(input int n);
        repeat (n) cyc();
        load_ready = 1'b1; cyc(); load_ready = 1'b0;
    endtask

    task automatic fill_ok(input int n);
        repeat (n) cyc();
        water_full = 1'b1; cyc(); water_full = 1'b0;
    endtask

    task automatic drain_ok(input int n);
        repeat (n) cyc();
        water_empty = 1'b1; cyc(); water_empty = 1'b0;
    endtask

    task automatic clear();
        clear_fault = 1'b1; cyc(); clear_fault = 1'b0;
    endtask

    task automatic run_nominal();
        int n;
        start_prog();
        check("sense entry", state, 1);
        check("sense_start first cycle", sense_start, 1);
        sense_ok(5);
        check("fill entry", {state, valve_open, sense_start}, {3'd2, 1'b1, 1'b0});
        fill_ok(8);
        check("wash entry", state, 3);
        n = 0;
        while (drum_motor && n < 200) begin n++; cyc(); end
        check("drum cycles", n, 20);
        check("after wash", state, 4);
        drain_ok(6);
        check("spin entry", {state, drain_pump, spin_motor}, {3'd5, 1'b1, 1'b1});
        n = 0;
        while (spin_motor && n < 200) begin n++; cyc(); end
        check("spin cycles", n, 10);
        check("done entry", {state, done, drain_pump}, {3'd6, 1'b1, 1'b0});
        start_btn = 1'b1; repeat (3) cyc(); start_btn = 1'b0;
        check("done ignores start", {state, done}, {3'd6, 1'b1});
        door_closed = 1'b0; cyc(); door_closed = 1'b1;
        check("door opens after done", {state, done}, {3'd0, 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int gaps[$];

        reset = 1'b0;
        repeat (3) cyc();
        check("reset state", state, 0);
        check("reset outputs", {sense_start, valve_open, drum_motor, drain_pump, spin_motor, done, fault}, 0);
        check("reset fault_code", fault_code, 0);
        reset = 1'b1;

        clear();
        check("clear outside fault", {state, fault}, 0);
        door_closed = 1'b0; start_btn = 1'b1; cyc(); start_btn = 1'b0; door_closed = 1'b1;
        check("start with door open ignored", state, 0);

        run_nominal();

        // Reset in the middle of WASH drops every actuator on the first reset edge.
        start_prog(); sense_ok(2); fill_ok(3); repeat (7) cyc();
        check("mid wash", {state, drum_motor}, {3'd3, 1'b1});
        reset = 1'b0; cyc();
        check("mid-wash reset state", state, 0);
        check("mid-wash reset outputs", {sense_start, valve_open, drum_motor, drain_pump, spin_motor, done, fault, fault_code}, 0);
        repeat (2) cyc();
        reset = 1'b1; cyc();
        check("idle after reset", state, 0);

        // load_ready never arrives: two one-cycle sense_start gaps, then sense fault.
        start_prog();
        n = 0;
        while (state == 3'd1 && n < 200) begin
            if (!sense_start) gaps.push_back(n);
            n++; cyc();
        end
        check("sense cycles before fault", n, 48);
        check("sense gap count", gaps.size(), 2);
        check("sense gap 0", (gaps.size() > 0) ? gaps[0] : -1, 16);
        check("sense gap 1", (gaps.size() > 1) ? gaps[1] : -1, 32);
        check("sense fault", {state, fault, fault_code, sense_start}, {3'd7, 1'b1, 2'd1, 1'b0});
        start_btn = 1'b1; repeat (3) cyc(); start_btn = 1'b0;
        check("fault ignores start", {state, fault_code}, {3'd7, 2'd1});
        clear();
        check("fault cleared", {state, fault, fault_code}, 0);

        // water_full never arrives: fill timeout after 16 valve cycles.
        start_prog(); sense_ok(0);
        n = 0;
        while (state == 3'd2 && n < 200) begin
            if (valve_open) n++;
            cyc();
        end
        check("fill valve cycles", n, 16);
        check("fill timeout fault", {state, fault_code, valve_open}, {3'd7, 2'd2, 1'b0});
        clear();

        // water_full together with door open: interlock wins.
        start_prog(); sense_ok(1); repeat (4) cyc();
        water_full = 1'b1; door_closed = 1'b0; cyc(); water_full = 1'b0; door_closed = 1'b1;
        check("door beats water_full", {state, fault_code, drum_motor}, {3'd7, 2'd3, 1'b0});
        clear();

        // Door opens on the last spin cycle: door fault, not DONE.
        start_prog(); sense_ok(1); fill_ok(2);
        n = 0;
        while (drum_motor && n < 200) begin n++; cyc(); end
        drain_ok(3);
        repeat (SPIN_N - 1) cyc();
        check("last spin cycle", {state, spin_motor}, {3'd5, 1'b1});
        door_closed = 1'b0; cyc(); door_closed = 1'b1;
        check("door at spin expiry", {state, fault_code, done, spin_motor, drain_pump}, {3'd7, 2'd3, 1'b0, 1'b0, 1'b0});
        clear();

        run_nominal();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
